fpga_plb_cfg: RTL and testbench

Parametrised programmable logic block with N_LC logic cells. Each cell has a K-input LUT, an optional registered output, and a ripple carry chain. The configuration is loaded word-by-word through a valid/ready loader FSM into shadow registers, then committed to all cells in a single cycle. Logic keeps running on the old configuration during a load. The block sits in the fabric tile in the same place as the fixed 8-cell PLB and replaces its parallel config bus with a streamed one.

---
 rtl/fpga_plb_cfg.sv | 180 ++++++++++++++++++
 tb/tb_fpga_plb_cfg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_plb_cfg.sv
// fpga_plb_cfg -- programmable logic block with a streamed configuration loader.
//
// N_LC logic cells. Each cell has a K-input LUT, an optional registered
// output and a ripple carry chain. Configuration words arrive through a
// valid/ready loader. The loader fills a shadow copy of the configuration
// while the logic keeps running on the active copy. All cells then switch
// to the new configuration in one cycle.
//
// Optional feature: define FPGA_PLB_CFG_PARITY_EN to check even parity on
// every accepted word. A frame with any bad word is loaded but not committed.
// cfg_err_o reports the error. Without the macro, cfg_parity_i is ignored and
// cfg_err_o is held at 0.
//
// Ports:
//   clk_i         clock
//   reset_ni      asynchronous active-low reset
//   cfg_start_i   begin or restart a configuration frame
//   cfg_valid_i   config word valid
//   cfg_ready_o   loader accepting words (high only in LOAD)
//   cfg_data_i    config word: [2**K-1:0] table, [2**K] SYNC, [2**K+1] CARRY
//   cfg_parity_i  even parity over cfg_data_i (optional feature only)
//   cfg_done_o    one-cycle pulse while the commit happens
//   cfg_err_o     sticky frame parity error (optional feature only)
//   fcin_i        carry into cell 0
//   fcout_o       carry out of cell N_LC-1
//   dffe_i        flip-flop enable shared by all cells
//   lut_i         cell n LUT inputs at [n*K +: K]
//   plb_lcs_o     cell outputs
module fpga_plb_cfg #(
    parameter int N_LC = 8,
    parameter int K    = 4,
    parameter int CW   = 2**K + 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cfg_start_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CW-1:0]     cfg_data_i,
    input  logic              cfg_parity_i,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    input  logic              fcin_i,
    output logic              fcout_o,
    input  logic              dffe_i,
    input  logic [N_LC*K-1:0] lut_i,
    output logic [N_LC-1:0]   plb_lcs_o
);

    localparam int TW    = 2**K;
    localparam int CNT_W = (N_LC > 1) ? $clog2(N_LC) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_LC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ready_reg;
    logic             done_reg;
    logic             err_reg;
    logic [CW-1:0]    shadow_reg [N_LC];
    logic [CW-1:0]    active_reg [N_LC];
    logic             ff_reg     [N_LC];
    logic [N_LC-1:0]  comb_bits;
    logic             word_bad;
    logic             take_word;

`ifdef FPGA_PLB_CFG_PARITY_EN
    assign word_bad = ^{cfg_data_i, cfg_parity_i};
`else
    logic unused_parity;
    assign unused_parity = cfg_parity_i;
    assign word_bad      = 1'b0;
`endif

    // A restart takes priority over a word offered in the same cycle.
    assign take_word   = ready_reg & cfg_valid_i & ~cfg_start_i;
    assign cfg_ready_o = ready_reg;
    assign cfg_done_o  = done_reg;
    assign cfg_err_o   = err_reg;

    // Loader FSM. done_reg is high exactly during COMMIT when the frame was
    // clean, and it also gates the shadow-to-active copy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_start_i) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        err_reg   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_start_i) begin
                        cnt_reg <= '0;
                        err_reg <= 1'b0;
                    end else if (take_word) begin
                        if (word_bad) begin
                            err_reg <= 1'b1;
                        end
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= COMMIT;
                            ready_reg <= 1'b0;
                            cnt_reg   <= '0;
                            done_reg  <= ~(err_reg | word_bad);
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Carry chain and LUT lookups. A sequential walk avoids a vector that
    // depends on its own lower bits.
    always_comb begin
        logic            c;
        logic [K-1:0]    in_v;
        logic [K-1:0]    addr;
        logic [TW-1:0]   tbl;
        c         = fcin_i;
        comb_bits = '0;
        in_v      = '0;
        addr      = '0;
        tbl       = '0;
        for (int n = 0; n < N_LC; n++) begin
            in_v = lut_i[n*K +: K];
            tbl  = active_reg[n][TW-1:0];
            if (active_reg[n][TW+1]) begin
                // Carry mode: the top LUT input is replaced by carry-in so the
                // table can form the sum bit.
                addr         = {c, in_v[K-2:0]};
                comb_bits[n] = tbl[addr];
                c            = (in_v[0] & in_v[1]) | (c & (in_v[0] ^ in_v[1]));
            end else begin
                addr         = in_v;
                comb_bits[n] = tbl[addr];
            end
        end
        fcout_o = c;
    end

    for (genvar gi = 0; gi < N_LC; gi++) begin : g_cell
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                shadow_reg[gi] <= '0;
                active_reg[gi] <= '0;
                ff_reg[gi]     <= 1'b0;
            end else begin
                if (take_word && (cnt_reg == CNT_W'(gi))) begin
                    shadow_reg[gi] <= cfg_data_i;
                end
                if (done_reg) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
                // The cell flip-flop is independent of the loader, so its
                // contents survive a commit.
                if (dffe_i) begin
                    ff_reg[gi] <= comb_bits[gi];
                end
            end
        end

        assign plb_lcs_o[gi] = active_reg[gi][TW] ? ff_reg[gi] : comb_bits[gi];
    end

endmodule

// File: tb/tb_fpga_plb_cfg.sv
// Directed testbench for fpga_plb_cfg (N_LC=8, K=4). Builds with or without
// FPGA_PLB_CFG_PARITY_EN; the parity scenario runs only when it is defined.
module tb_fpga_plb_cfg;

    localparam int N_LC = 8;
    localparam int K    = 4;
    localparam int CW   = 18;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              cfg_start_i;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [CW-1:0]     cfg_data_i;
    logic              cfg_parity_i;
    logic              cfg_done_o;
    logic              cfg_err_o;
    logic              fcin_i;
    logic              fcout_o;
    logic              dffe_i;
    logic [N_LC*K-1:0] lut_i;
    logic [N_LC-1:0]   plb_lcs_o;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int done_ref = 0;

    fpga_plb_cfg #(.N_LC(N_LC), .K(K)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .cfg_start_i  (cfg_start_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_data_i   (cfg_data_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_done_o   (cfg_done_o),
        .cfg_err_o    (cfg_err_o),
        .fcin_i       (fcin_i),
        .fcout_o      (fcout_o),
        .dffe_i       (dffe_i),
        .lut_i        (lut_i),
        .plb_lcs_o    (plb_lcs_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (cfg_done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_frame();
        cfg_start_i = 1'b1;
        step();
        cfg_start_i = 1'b0;
    endtask

    task automatic send_word(input logic [CW-1:0] w, input logic bad);
        cfg_data_i   = w;
        cfg_parity_i = (^w) ^ bad;
        cfg_valid_i  = 1'b1;
        step();
        cfg_valid_i  = 1'b0;
    endtask

    // Sends a whole frame of identical words; returns #1 after the last accept.
    task automatic load_frame(input logic [CW-1:0] w, input int gap_after, input int bad_idx);
        start_frame();
        for (int i = 0; i < N_LC; i++) begin
            send_word(w, (i == bad_idx));
            if (i == gap_after) begin
                step();
                step();
            end
        end
    endtask

    initial begin
        reset_ni     = 1'b0;
        cfg_start_i  = 1'b0;
        cfg_valid_i  = 1'b0;
        cfg_data_i   = '0;
        cfg_parity_i = 1'b0;
        fcin_i       = 1'b1;
        dffe_i       = 1'b0;
        lut_i        = '0;

        // 1. Reset state
        step();
        step();
        check("rst_lcs", 32'(plb_lcs_o), 32'h00);
        check("rst_fcout", 32'(fcout_o), 32'h1);
        check("rst_ready", 32'(cfg_ready_o), 32'h0);
        check("rst_done", 32'(cfg_done_o), 32'h0);
        check("rst_err", 32'(cfg_err_o), 32'h0);
        reset_ni = 1'b1;
        step();
        check("idle_ready", 32'(cfg_ready_o), 32'h0);

        // 2. AND-4 table in every cell, valid gap mid-frame
        done_ref = done_cnt;
        load_frame(18'h08000, 3, -1);
        check("t2_done_pulse", 32'(cfg_done_o), 32'h1);
        check("t2_ready_cmt", 32'(cfg_ready_o), 32'h0);
        step();
        check("t2_done_low", 32'(cfg_done_o), 32'h0);
        check("t2_done_cnt", 32'(done_cnt - done_ref), 32'h1);
        lut_i = 32'hFFFF_FFFF;
        #1;
        check("t2_all_ones", 32'(plb_lcs_o), 32'hFF);
        lut_i = 32'hFFFF_EFFF;
        #1;
        check("t2_cell3_e", 32'(plb_lcs_o), 32'hF7);

        // 3. Carry mode sum table: in0 bits F0, in1 bits 0F
        load_frame(18'h29966, -1, -1);
        step();
        lut_i  = 32'h1111_2222;
        fcin_i = 1'b1;
        #1;
        check("t3_sum_cin1", 32'(plb_lcs_o), 32'h00);
        check("t3_cout_cin1", 32'(fcout_o), 32'h1);
        fcin_i = 1'b0;
        #1;
        check("t3_sum_cin0", 32'(plb_lcs_o), 32'hFF);
        check("t3_cout_cin0", 32'(fcout_o), 32'h0);
        // cell 0 generates a carry that cell 1 absorbs
        lut_i = 32'h0000_0003;
        #1;
        check("t3_gen_sum", 32'(plb_lcs_o), 32'h02);
        check("t3_gen_cout", 32'(fcout_o), 32'h0);

        // 4. Registered outputs
        load_frame(18'h1FFFF, -1, -1);
        step();
        check("t4_ff_zero", 32'(plb_lcs_o), 32'h00);
        dffe_i = 1'b1;
        #1;
        check("t4_before_edge", 32'(plb_lcs_o), 32'h00);
        step();
        dffe_i = 1'b0;
        check("t4_captured", 32'(plb_lcs_o), 32'hFF);
        step();
        check("t4_hold", 32'(plb_lcs_o), 32'hFF);
        load_frame(18'h10000, -1, -1);
        step();
        check("t4_reload_keep", 32'(plb_lcs_o), 32'hFF);
        dffe_i = 1'b1;
        step();
        dffe_i = 1'b0;
        check("t4_recapture", 32'(plb_lcs_o), 32'h00);

        // 5. Restart mid-frame; restart collides with a valid word
        done_ref = done_cnt;
        start_frame();
        for (int i = 0; i < 5; i++) begin
            send_word(18'h0FFFF, 1'b0);
        end
        cfg_data_i   = 18'h0FFFF;
        cfg_parity_i = ^cfg_data_i;
        cfg_valid_i  = 1'b1;
        cfg_start_i  = 1'b1;
        step();
        cfg_start_i  = 1'b0;
        cfg_valid_i  = 1'b0;
        check("t5_ready_rst", 32'(cfg_ready_o), 32'h1);
        for (int i = 0; i < N_LC; i++) begin
            send_word(18'h00001, 1'b0);
        end
        check("t5_done_pulse", 32'(cfg_done_o), 32'h1);
        step();
        step();
        check("t5_done_cnt", 32'(done_cnt - done_ref), 32'h1);
        lut_i = 32'hFFFF_FFFF;
        #1;
        check("t5_ones", 32'(plb_lcs_o), 32'h00);
        lut_i = 32'h0000_0000;
        #1;
        check("t5_zeros", 32'(plb_lcs_o), 32'hFF);

`ifdef FPGA_PLB_CFG_PARITY_EN
        // 6. Bad parity on word 2: frame loads but is not committed
        lut_i    = 32'hFFFF_FFFF;
        done_ref = done_cnt;
        load_frame(18'h0FFFF, -1, 2);
        check("t6_err_set", 32'(cfg_err_o), 32'h1);
        check("t6_no_done", 32'(cfg_done_o), 32'h0);
        step();
        step();
        check("t6_done_cnt", 32'(done_cnt - done_ref), 32'h0);
        check("t6_old_cfg", 32'(plb_lcs_o), 32'h00);
        check("t6_err_sticky", 32'(cfg_err_o), 32'h1);
        start_frame();
        check("t6_err_clear", 32'(cfg_err_o), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
